// File: rtl/fft_frame_ctrl_if.sv
// Stream channels around the FFT frame controller.
// Carries upstream samples, FFT core config/data-in/data-out, and the downstream result stream.
interface fft_frame_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int MAX_LOG2N = 10,
  parameter int CFG_W     = 16
);
  logic [DATA_W-1:0]    s_in_tdata;
  logic                 s_in_tvalid;
  logic                 s_in_tready;
  logic [CFG_W-1:0]     cfg_tdata;
  logic                 cfg_tvalid;
  logic                 cfg_tready;
  logic [DATA_W-1:0]    fft_s_tdata;
  logic                 fft_s_tvalid;
  logic                 fft_s_tlast;
  logic                 fft_s_tready;
  logic [2*DATA_W-1:0]  fft_m_tdata;
  logic                 fft_m_tvalid;
  logic                 fft_m_tlast;
  logic                 fft_m_tready;
  logic [DATA_W-1:0]    out_re;
  logic [DATA_W-1:0]    out_im;
  logic [MAX_LOG2N-1:0] out_index;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  s_in_tdata, s_in_tvalid, output s_in_tready,
    output cfg_tdata, cfg_tvalid, input cfg_tready,
    output fft_s_tdata, fft_s_tvalid, fft_s_tlast, input fft_s_tready,
    input  fft_m_tdata, fft_m_tvalid, fft_m_tlast, output fft_m_tready,
    output out_re, out_im, out_index, out_last, out_valid, input out_ready
  );

  modport slave (
    output s_in_tdata, s_in_tvalid, input s_in_tready,
    input  cfg_tdata, cfg_tvalid, output cfg_tready,
    input  fft_s_tdata, fft_s_tvalid, fft_s_tlast, output fft_s_tready,
    output fft_m_tdata, fft_m_tvalid, fft_m_tlast, input fft_m_tready,
    input  out_re, out_im, out_index, out_last, out_valid, output out_ready
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer around a streaming FFT core: configures the core, frames the input stream,
// indexes results and tracks status for a fixed or continuous number of frames.
module fft_frame_ctrl #(
  parameter int DATA_W    = 32,
  parameter int MAX_LOG2N = 10,
  parameter int CFG_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [4:0]            log2n,
  input  logic                  inverse,
  input  logic [15:0]           frames,
  fft_frame_ctrl_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            err,
  output logic [15:0]           frames_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONFIG = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  localparam logic [MAX_LOG2N-1:0] IDX_ZERO = {MAX_LOG2N{1'b0}};
  localparam logic [MAX_LOG2N-1:0] IDX_ONE  = {{(MAX_LOG2N-1){1'b0}}, 1'b1};

  logic [1:0]           state_r, state_nx_s;
  logic [4:0]           log2n_r;
  logic                 inverse_r;
  logic [15:0]          frames_r;
  logic [MAX_LOG2N-1:0] in_cnt_r, out_idx_r, last_idx_s;
  logic [MAX_LOG2N:0]   frame_len_s, last_full_s;
  logic [15:0]          in_frames_r, in_frames_inc_s, frames_out_r;
  logic                 stop_seen_r, busy_r, done_r;
  logic [2:0]           err_r, err_nx_s, err_set_s;
  logic                 in_stream_s, out_act_s, size_ok_s, start_ok_s;
  logic                 in_xfer_s, in_last_xfer_s, out_xfer_s, stream_end_s;

  function automatic logic [CFG_W-1:0] cfg_word(input logic [4:0] l2n, input logic inv);
    logic [CFG_W-1:0] w;
    w      = {CFG_W{1'b0}};
    w[8]   = ~inv;
    w[4:0] = l2n;
    return w;
  endfunction

  assign size_ok_s   = (log2n >= 5'd3) && ({27'd0, log2n} <= 32'(MAX_LOG2N));
  assign start_ok_s  = (state_r == ST_IDLE) && start && size_ok_s;
  assign frame_len_s = {{MAX_LOG2N{1'b0}}, 1'b1} << log2n_r;
  assign last_full_s = frame_len_s - {{MAX_LOG2N{1'b0}}, 1'b1};
  assign last_idx_s  = last_full_s[MAX_LOG2N-1:0];
  assign in_stream_s = (state_r == ST_STREAM);
  assign out_act_s   = (state_r == ST_STREAM) || (state_r == ST_DRAIN);

  // Input path is a direct pass-through while streaming; the frame boundary comes from our own count.
  assign bus.fft_s_tdata  = bus.s_in_tdata;
  assign bus.fft_s_tvalid = in_stream_s && bus.s_in_tvalid;
  assign bus.s_in_tready  = in_stream_s && bus.fft_s_tready;
  assign bus.fft_s_tlast  = in_stream_s && (in_cnt_r == last_idx_s);
  assign bus.cfg_tvalid   = (state_r == ST_CONFIG);
  assign bus.cfg_tdata    = cfg_word(log2n_r, inverse_r);

  assign in_xfer_s       = bus.fft_s_tvalid && bus.fft_s_tready;
  assign in_last_xfer_s  = in_xfer_s && bus.fft_s_tlast;
  assign in_frames_inc_s = (in_frames_r == CNT_MAX) ? in_frames_r : in_frames_r + 16'd1;
  assign stream_end_s    = in_last_xfer_s &&
                           ((frames_r != 16'd0) ? (in_frames_inc_s == frames_r) : (stop || stop_seen_r));

  assign bus.fft_m_tready = out_act_s && bus.out_ready;
  assign bus.out_valid    = out_act_s && bus.fft_m_tvalid;
  assign bus.out_re       = bus.fft_m_tdata[DATA_W-1:0];
  assign bus.out_im       = bus.fft_m_tdata[2*DATA_W-1:DATA_W];
  assign bus.out_index    = out_idx_r;
  assign bus.out_last     = out_act_s && (out_idx_r == last_idx_s);
  assign out_xfer_s       = bus.out_valid && bus.out_ready;

  // Set conditions win over the clear from an accepted start in the same cycle.
  assign err_set_s = {(!out_act_s && bus.fft_m_tvalid),
                      (out_xfer_s && (bus.fft_m_tlast != bus.out_last)),
                      ((state_r == ST_IDLE) && start && !size_ok_s)};
  assign err_nx_s  = (start_ok_s ? 3'b000 : err_r) | err_set_s;

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign frames_out = frames_out_r;

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:   if (start_ok_s) state_nx_s = ST_CONFIG; else state_nx_s = ST_IDLE;
      ST_CONFIG: if (bus.cfg_tready) state_nx_s = ST_STREAM; else state_nx_s = ST_CONFIG;
      ST_STREAM: if (stream_end_s) state_nx_s = ST_DRAIN; else state_nx_s = ST_STREAM;
      ST_DRAIN:  if (frames_out_r == in_frames_r) state_nx_s = ST_IDLE; else state_nx_s = ST_DRAIN;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // State, status flags and run settings.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 3'b000;
      log2n_r   <= 5'd0;
      inverse_r <= 1'b0;
      frames_r  <= 16'd0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_r == ST_DRAIN) && (state_nx_s == ST_IDLE);
      err_r   <= err_nx_s;
      if ((state_r == ST_IDLE) && start) begin
        log2n_r   <= log2n;
        inverse_r <= inverse;
        frames_r  <= frames;
      end
    end
  end

  // Sample, frame and result counters; all restart on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok_s) begin
      in_cnt_r     <= IDX_ZERO;
      in_frames_r  <= 16'd0;
      out_idx_r    <= IDX_ZERO;
      frames_out_r <= 16'd0;
      stop_seen_r  <= 1'b0;
    end else begin
      if (in_xfer_s) begin
        in_cnt_r <= bus.fft_s_tlast ? IDX_ZERO : in_cnt_r + IDX_ONE;
      end
      if (in_last_xfer_s) begin
        in_frames_r <= in_frames_inc_s;
      end
      if (in_stream_s && stop) begin
        stop_seen_r <= 1'b1;
      end
      if (out_xfer_s) begin
        out_idx_r <= bus.out_last ? IDX_ZERO : out_idx_r + IDX_ONE;
        if (bus.out_last && (frames_out_r != CNT_MAX)) begin
          frames_out_r <= frames_out_r + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench: emulates source, FFT core and sink with random handshakes and
// compares every cycle against a transfer-counting behavioural model.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
  localparam int DW = 32;
  localparam int ML = 10;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, inverse = 1'b0;
  logic [4:0] log2n = 5'd0;
  logic [15:0] frames = 16'd0;
  logic busy, done;
  logic [2:0] err;
  logic [15:0] frames_out;

  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.DATA_W(DW), .MAX_LOG2N(ML), .CFG_W(CW)) bus ();

  fft_frame_ctrl #(.DATA_W(DW), .MAX_LOG2N(ML), .CFG_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .log2n(log2n),
    .inverse(inverse), .frames(frames), .bus(bus), .busy(busy), .done(done),
    .err(err), .frames_out(frames_out)
  );

  int total = 0;
  int bad = 0;

  // Model: phase 0 idle, 1 config, 2 stream, 3 drain
  int ph = 0, m_l2n = 0, m_n = 1, m_inv = 0, m_frames = 0;
  int m_in_cnt = 0, m_in_frames = 0, m_out_cnt = 0, m_out_frames = 0;
  bit m_stop_seen = 0, m_done = 0;
  logic [2:0] m_err = 3'b000;
  int m_x = 0, cfg_cycles = 0;
  int tl_q[$];

  int p_in = 100, p_rdy = 100, p_cfg = 100, p_out = 100, p_mv = 100, early = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model each cycle, then advance the model.
  initial begin : compare
    int nph;
    bit nd, in_x, out_x, stop_now;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", busy, ph != 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("frames_out", frames_out, (m_out_frames > 65535) ? 65535 : m_out_frames);
      chk("cfg_tvalid", bus.cfg_tvalid, ph == 1);
      if (ph == 1) chk("cfg_tdata", bus.cfg_tdata, (m_inv != 0 ? 0 : 256) + m_l2n);
      chk("s_in_tready", bus.s_in_tready, (ph == 2) && bus.fft_s_tready);
      chk("fft_s_tvalid", bus.fft_s_tvalid, (ph == 2) && bus.s_in_tvalid);
      if (ph == 2) begin
        chk("fft_s_tdata", bus.fft_s_tdata, bus.s_in_tdata);
        chk("fft_s_tlast", bus.fft_s_tlast, m_in_cnt == m_n - 1);
      end
      chk("fft_m_tready", bus.fft_m_tready, (ph >= 2) && bus.out_ready);
      chk("out_valid", bus.out_valid, (ph >= 2) && bus.fft_m_tvalid);
      if (ph >= 2) begin
        chk("out_re", bus.out_re, bus.fft_m_tdata[DW-1:0]);
        chk("out_im", bus.out_im, bus.fft_m_tdata[2*DW-1:DW]);
        chk("out_index", bus.out_index, m_out_cnt);
        chk("out_last", bus.out_last, m_out_cnt == m_n - 1);
      end
      if (bus.cfg_tvalid) cfg_cycles++;
      if (ph == 2 && bus.s_in_tvalid && bus.fft_s_tready) begin
        if (bus.fft_s_tlast) tl_q.push_back(m_x);
        m_x++;
      end
      if (!rst_n) begin
        ph = 0; m_in_cnt = 0; m_in_frames = 0; m_out_cnt = 0; m_out_frames = 0;
        m_err = 3'b000; m_done = 0; m_stop_seen = 0;
      end else begin
        nph = ph; nd = 0;
        in_x  = (ph == 2) && bus.s_in_tvalid && bus.fft_s_tready;
        out_x = (ph >= 2) && bus.fft_m_tvalid && bus.out_ready;
        if (ph == 0 && start) begin
          m_l2n = int'(log2n); m_inv = int'(inverse); m_frames = int'(frames); m_n = 1 << m_l2n;
          if (m_l2n >= 3 && m_l2n <= ML) begin
            nph = 1; m_err = 3'b000; m_in_cnt = 0; m_in_frames = 0;
            m_out_cnt = 0; m_out_frames = 0; m_stop_seen = 0;
          end else m_err[0] = 1'b1;
        end
        if (ph <= 1 && bus.fft_m_tvalid) m_err[2] = 1'b1;
        if (ph == 1 && bus.cfg_tready) nph = 2;
        if (ph == 3 && m_out_frames == m_in_frames) begin nph = 0; nd = 1; end
        if (in_x) begin
          stop_now = m_stop_seen || stop;
          if (m_in_cnt == m_n - 1) begin
            m_in_cnt = 0; m_in_frames++;
            if (m_frames != 0 ? (m_in_frames == m_frames) : stop_now) nph = 3;
          end else m_in_cnt++;
        end
        if (ph == 2 && stop) m_stop_seen = 1;
        if (out_x) begin
          if (bus.fft_m_tlast != (m_out_cnt == m_n - 1)) m_err[1] = 1'b1;
          if (m_out_cnt == m_n - 1) begin m_out_cnt = 0; m_out_frames++; end
          else m_out_cnt++;
        end
        ph = nph; m_done = nd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source, FFT core emulation and sink, one random draw per cycle.
  task automatic drive();
    bus.s_in_tvalid  = ($urandom_range(99) < p_in);
    bus.s_in_tdata   = $urandom;
    bus.fft_s_tready = ($urandom_range(99) < p_rdy);
    bus.cfg_tready   = ($urandom_range(99) < p_cfg);
    bus.out_ready    = ($urandom_range(99) < p_out);
    bus.fft_m_tdata  = {$urandom, $urandom};
    if (m_out_frames < m_in_frames && $urandom_range(99) < p_mv) begin
      bus.fft_m_tvalid = 1'b1;
      bus.fft_m_tlast  = (m_out_cnt == m_n - 1 - early);
    end else begin
      bus.fft_m_tvalid = 1'b0;
      bus.fft_m_tlast  = 1'b0;
    end
  endtask

  task automatic run(input int l2n, input int inv, input int nfr, input int stop_fr, input int stop_smp);
    bit got = 0, stop_sent = 0;
    tl_q.delete(); m_x = 0; cfg_cycles = 0;
    log2n = 5'(l2n); inverse = 1'(inv); frames = 16'(nfr); start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    drive();
    for (int c = 0; c < 40000 && !got; c++) begin
      tick();
      if (done) got = 1;
      stop = 1'b0;
      if (stop_fr >= 0 && !stop_sent && ph == 2 && m_in_frames == stop_fr && m_in_cnt == stop_smp) begin
        stop = 1'b1; stop_sent = 1;
      end
      drive();
    end
    stop = 1'b0;
    chk("done_seen", got, 1);
  endtask

  initial begin : stim
    bus.s_in_tvalid = 1'b0; bus.s_in_tdata = '0; bus.fft_s_tready = 1'b0; bus.cfg_tready = 1'b0;
    bus.out_ready = 1'b0; bus.fft_m_tdata = '0; bus.fft_m_tvalid = 1'b0; bus.fft_m_tlast = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_frames_out", frames_out, 0);
    chk("rst_cfg_tvalid", bus.cfg_tvalid, 0);
    chk("rst_out_valid", bus.out_valid, 0);

    // Basic two-frame run, start on the first edge after reset release
    rst_n = 1'b1;
    drive();
    run(3, 0, 2, -1, 0);
    chk("b_cfg_cycles", cfg_cycles, 1);
    chk("b_tl_cnt", tl_q.size(), 2);
    chk("b_tl0", tl_q[0], 7);
    chk("b_tl1", tl_q[1], 15);
    chk("b_frames_out", frames_out, 2);
    chk("b_err", err, 0);

    // Large frames with random gaps on every handshake
    p_in = 60; p_rdy = 60; p_cfg = 50; p_out = 70; p_mv = 70;
    tick(); drive();
    run(10, 1, 2, -1, 0);
    chk("l_tl_cnt", tl_q.size(), 2);
    chk("l_tl0", tl_q[0], 1023);
    chk("l_tl1", tl_q[1], 2047);
    chk("l_xfers", m_x, 2048);
    chk("l_frames_out", frames_out, 2);

    // Continuous mode, stop mid frame 3
    tick(); drive();
    run(4, 1, 0, 2, 5);
    chk("c_tl_cnt", tl_q.size(), 3);
    chk("c_tl2", tl_q[2], 47);
    chk("c_xfers", m_x, 48);
    chk("c_frames_out", frames_out, 3);

    // Rejected sizes
    foreach (tl_q[i]) tl_q[i] = 0;
    for (int k = 0; k < 2; k++) begin
      tick(); drive();
      log2n = (k == 0) ? 5'd2 : 5'd11; start = 1'b1;
      tick(); start = 1'b0; drive();
      chk("bad_err", err, 3'b001);
      chk("bad_busy", busy, 0);
    end

    // Unexpected FFT output while idle
    tick(); drive(); bus.fft_m_tvalid = 1'b1;
    chk("idle_m_tready", bus.fft_m_tready, 0);
    tick(); drive();
    chk("idle_err", err, 3'b101);

    // Core tlast one beat early
    early = 1;
    tick(); drive();
    run(3, 0, 1, -1, 0);
    chk("mis_err", err, 3'b010);
    chk("mis_frames_out", frames_out, 1);
    early = 0;

    // Reset mid-stream, then a clean run starting on the release edge
    tick(); drive();
    log2n = 5'd4; frames = 16'd3; start = 1'b1;
    tick(); start = 1'b0; drive();
    for (int c = 0; c < 2000 && m_x < 20; c++) begin tick(); drive(); end
    chk("mid_in_stream", ph, 2);
    rst_n = 1'b0;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_cfg_tvalid", bus.cfg_tvalid, 0);
    chk("mr_fft_s_tvalid", bus.fft_s_tvalid, 0);
    chk("mr_fft_s_tlast", bus.fft_s_tlast, 0);
    chk("mr_s_in_tready", bus.s_in_tready, 0);
    chk("mr_fft_m_tready", bus.fft_m_tready, 0);
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_frames_out", frames_out, 0);
    rst_n = 1'b1;
    drive();
    run(4, 0, 1, -1, 0);
    chk("r_tl_cnt", tl_q.size(), 1);
    chk("r_tl0", tl_q[0], 15);
    chk("r_frames_out", frames_out, 1);
    chk("r_err", err, 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
